// File: rtl/bubble_sort_ctrl.sv
// Control and compare/swap stage of the bubble-sort engine: drives the external
// inner-index counter, reads adjacent elements, writes swapped pairs, exits early on a clean pass.
module bubble_sort_ctrl #(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR,
  output logic         CNT_EN,
  output logic         CNT_LOAD,
  output logic [4:0]   CNT_PIN,
  input  logic [4:0]   CNT_POUT,
  input  logic         CNT_COUT,
  output logic [4:0]   MEM_ADDR,
  input  logic [W-1:0] MEM_RDATA,
  output logic [W-1:0] MEM_WDATA,
  output logic         MEM_WE
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_RDA, S_RDB, S_CMP, S_WRA, S_WRB, S_NEXT, S_PASS_END, S_DONE
  } state_t;

  localparam logic [4:0] LAST_P = 5'(N - 2);

  state_t       state_reg;
  logic [3:0]   p_reg;
  logic         swapped_reg;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic         busy_reg;
  logic         done_reg;
  logic         err_reg;
  logic         cnt_en_reg;
  logic         cnt_load_reg;
  logic         mem_we_reg;
  logic [W-1:0] wdata_reg;
  logic         addr_en_reg;
  logic         addr_off_reg;

  logic [4:0]   last_j;
  logic         at_last;

  assign last_j  = LAST_P - {1'b0, p_reg};
  assign at_last = (CNT_POUT == last_j);

  // The address follows the live counter value, since j only becomes valid in the cycle after EN/LOAD.
  assign MEM_ADDR  = addr_en_reg ? (CNT_POUT + {4'b0, addr_off_reg}) : 5'd0;
  assign MEM_WDATA = wdata_reg;
  assign MEM_WE    = mem_we_reg;
  assign BUSY      = busy_reg;
  assign DONE      = done_reg;
  assign ERR       = err_reg;
  assign CNT_EN    = cnt_en_reg;
  assign CNT_LOAD  = cnt_load_reg;
  assign CNT_PIN   = 5'd0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      p_reg        <= '0;
      swapped_reg  <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      cnt_en_reg   <= 1'b0;
      cnt_load_reg <= 1'b0;
      mem_we_reg   <= 1'b0;
      wdata_reg    <= '0;
      addr_en_reg  <= 1'b0;
      addr_off_reg <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      cnt_en_reg   <= 1'b0;
      cnt_load_reg <= 1'b0;
      mem_we_reg   <= 1'b0;
      addr_en_reg  <= 1'b0;
      addr_off_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (START) begin
            state_reg    <= S_INIT;
            err_reg      <= 1'b0;
            p_reg        <= '0;
            swapped_reg  <= 1'b0;
            busy_reg     <= 1'b1;
            cnt_load_reg <= 1'b1;
          end
        end
        S_INIT: begin
          state_reg   <= S_RDA;
          addr_en_reg <= 1'b1;
        end
        S_RDA: begin
          a_reg <= MEM_RDATA;
          if (CNT_COUT) begin
            err_reg   <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            state_reg    <= S_RDB;
            addr_en_reg  <= 1'b1;
            addr_off_reg <= 1'b1;
          end
        end
        S_RDB: begin
          b_reg     <= MEM_RDATA;
          state_reg <= S_CMP;
        end
        S_CMP: begin
          if (a_reg > b_reg) begin
            swapped_reg <= 1'b1;
            state_reg   <= S_WRA;
            mem_we_reg  <= 1'b1;
            wdata_reg   <= b_reg;
            addr_en_reg <= 1'b1;
          end else begin
            state_reg  <= S_NEXT;
            cnt_en_reg <= !at_last;
          end
        end
        S_WRA: begin
          state_reg    <= S_WRB;
          mem_we_reg   <= 1'b1;
          wdata_reg    <= a_reg;
          addr_en_reg  <= 1'b1;
          addr_off_reg <= 1'b1;
        end
        S_WRB: begin
          state_reg  <= S_NEXT;
          cnt_en_reg <= !at_last;
        end
        S_NEXT: begin
          // cnt_en_reg already carries the "more compares in this pass" decision.
          if (cnt_en_reg) begin
            state_reg   <= S_RDA;
            addr_en_reg <= 1'b1;
          end else begin
            state_reg    <= S_PASS_END;
            cnt_load_reg <= swapped_reg && ({1'b0, p_reg} != LAST_P);
          end
        end
        S_PASS_END: begin
          if (cnt_load_reg) begin
            p_reg       <= p_reg + 4'd1;
            swapped_reg <= 1'b0;
            state_reg   <= S_RDA;
            addr_en_reg <= 1'b1;
          end else begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
